minmax_stream: RTL and testbench



---
 rtl/minmax_stream.sv | 123 ++++++++++++
 tb/tb_minmax_stream.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/minmax_stream.sv
// Streaming min/max search: takes one element per beat and, at the end of each frame,
// reports the extreme value, its earliest index, and the frame length.
module minmax_stream #(
  parameter int unsigned W      = 8,
  parameter int unsigned NI     = 9,
  parameter int unsigned IDXW   = $clog2(NI),
  parameter int unsigned MM_CFG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              min_max_sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      result,
  output logic [IDXW-1:0]   index,
  output logic [IDXW:0]     count
);

  localparam int unsigned CW = IDXW + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    acc, acc_nxt;
  logic [IDXW-1:0] acc_idx, acc_idx_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            mode_max, mode_max_nxt;
  logic            beat;
  logic            is_max;
  logic            better;
  logic            frame_end;

  // State and running accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      acc_idx  <= '0;
      cnt      <= '0;
      mode_max <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      acc_idx  <= acc_idx_nxt;
      cnt      <= cnt_nxt;
      mode_max <= mode_max_nxt;
    end
  end

  // Next-state and accumulator update; strict compare keeps the earliest index on ties
  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    acc_idx_nxt  = acc_idx;
    cnt_nxt      = cnt;
    mode_max_nxt = mode_max;
    frame_end    = 1'b0;
    beat         = in_valid & in_ready;

    if (MM_CFG == 1) begin
      is_max = 1'b0;
    end else if (MM_CFG == 2) begin
      is_max = 1'b1;
    end else begin
      is_max = (state == IDLE) ? min_max_sel : mode_max;
    end
    better = is_max ? (in_data > acc) : (in_data < acc);

    case (state)
      IDLE: begin
        if (beat) begin
          acc_nxt      = in_data;
          acc_idx_nxt  = '0;
          cnt_nxt      = CW'(1);
          mode_max_nxt = is_max;
          frame_end    = in_last;
          state_nxt    = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          if (better) begin
            acc_nxt     = in_data;
            acc_idx_nxt = IDXW'(cnt);
          end
          cnt_nxt   = cnt + CW'(1);
          frame_end = in_last | (cnt_nxt == CW'(NI));
          state_nxt = frame_end ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered handshake flags and result, captured only when a frame completes
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      index     <= '0;
      count     <= '0;
    end else begin
      in_ready  <= (state_nxt != HOLD);
      out_valid <= (state_nxt == HOLD);
      if (frame_end) begin
        result <= acc_nxt;
        index  <= acc_idx_nxt;
        count  <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_minmax_stream.sv
// Scoreboard bench for minmax_stream: directed frames plus randomized frames checked
// against a queue-based reference model.
module tb_minmax_stream;

  localparam int unsigned W    = 8;
  localparam int unsigned NI   = 9;
  localparam int unsigned IDXW = 4;

  typedef struct packed {
    logic [W-1:0]    res;
    logic [IDXW-1:0] idx;
    logic [IDXW:0]   cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            min_max_sel;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    result;
  logic [IDXW-1:0] index;
  logic [IDXW:0]   count;

  int   n_vec = 0;
  int   n_err = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
  exp_t sb[$];

  minmax_stream #(.W(W), .NI(NI), .IDXW(IDXW), .MM_CFG(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .min_max_sel (min_max_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .index       (index),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: extreme value via queue reductions, index of its first occurrence
  function automatic exp_t model(input logic [W-1:0] q[$], input bit sel);
    logic [W-1:0] ext[$];
    int           pos[$];
    exp_t         e;
    if (sel) ext = q.max();
    else     ext = q.min();
    pos   = q.find_first_index(x) with (x == ext[0]);
    e.res = ext[0];
    e.idx = IDXW'(pos[0]);
    e.cnt = (IDXW+1)'(q.size());
    return e;
  endfunction

  task automatic send_beat(input logic [W-1:0] d, input bit last, input bit sel);
    int g = 0;
    in_valid    = 1'b1;
    in_data     = d;
    in_last     = last;
    min_max_sel = sel;
    while (!in_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_data     = 8'($urandom);
    min_max_sel = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [W-1:0] q[$], input bit sel, input int maxgap);
    exp_t e;
    bit   last;
    e = model(q, sel);
    for (int k = 0; k < q.size(); k++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      last = 1'b0;
      if (k == q.size() - 1) begin
        last = (q.size() < NI) ? 1'b1 : 1'($urandom_range(0, 1));
        sb.push_back(e);
      end
      send_beat(q[k], last, (k == 0) ? sel : 1'($urandom_range(0, 1)));
    end
    check("latency_out_valid", 32'(out_valid), 1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((out_valid || sb.size() != 0) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("drain_out_valid", 32'(out_valid), 0);
    check("drain_sb_empty", 32'(sb.size()), 0);
  endtask

  // Monitor: pops one expectation per presented result, checks it stays stable in HOLD
  initial begin : monitor
    bit   pending = 1'b0;
    bit   cur_ok  = 1'b0;
    exp_t cur;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (!pending) begin
          pending = 1'b1;
          if (sb.size() == 0) begin
            check("unexpected_output", 32'(out_valid), 0);
            cur_ok = 1'b0;
          end else begin
            cur    = sb.pop_front();
            cur_ok = 1'b1;
            check("result", 32'(result), 32'(cur.res));
            check("index", 32'(index), 32'(cur.idx));
            check("count", 32'(count), 32'(cur.cnt));
          end
        end else if (cur_ok) begin
          check("hold_result", 32'(result), 32'(cur.res));
          check("hold_index", 32'(index), 32'(cur.idx));
          check("hold_count", 32'(count), 32'(cur.cnt));
        end
        check("in_ready_in_hold", 32'(in_ready), 0);
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      if (out_valid && out_ready) pending = 1'b0;
    end
  end

  initial begin : stim
    logic [W-1:0] q[$];
    int           len;
    int           hi;
    bit           sel;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    min_max_sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result", 32'(result), 0);
    check("rst_index", 32'(index), 0);
    check("rst_count", 32'(count), 0);

    // Min over a frame with a tied minimum
    q = '{8'd5, 8'd3, 8'd8, 8'd3, 8'd200, 8'd0, 8'd7, 8'd0, 8'd9};
    send_frame(q, 1'b0, 0);
    check("t1_result", 32'(result), 0);
    check("t1_index", 32'(index), 5);
    check("t1_count", 32'(count), 9);
    wait_idle();

    // Same data, max mode
    send_frame(q, 1'b1, 1);
    check("t2_result", 32'(result), 200);
    check("t2_index", 32'(index), 4);
    check("t2_count", 32'(count), 9);
    wait_idle();

    // Early termination via in_last
    q = '{8'd10, 8'd20, 8'd30};
    send_frame(q, 1'b1, 0);
    check("t3_result", 32'(result), 30);
    check("t3_index", 32'(index), 2);
    check("t3_count", 32'(count), 3);
    check("t3_in_ready_hold", 32'(in_ready), 0);
    wait_idle();

    // Back-pressure in HOLD while upstream keeps offering beats
    rdy_mode = 2;
    send_frame(q, 1'b0, 0);
    repeat (5) begin
      in_valid = 1'b1;
      in_data  = 8'd1;
      in_last  = 1'b1;
      @(negedge clk);
      check("t4_out_valid", 32'(out_valid), 1);
      check("t4_result", 32'(result), 10);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    rdy_mode = 0;
    wait_idle();
    check("t4_in_ready_after", 32'(in_ready), 1);
    check("t4_result_kept", 32'(result), 10);

    // Reset in the middle of a frame discards it
    for (int k = 0; k < 4; k++) send_beat(8'(k + 40), 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_in_ready", 32'(in_ready), 1);
    q = {};
    for (int k = 0; k < NI; k++) q.push_back(8'hFF);
    send_frame(q, 1'b0, 0);
    check("t5_result", 32'(result), 255);
    check("t5_index", 32'(index), 0);
    wait_idle();

    // Random frames with gaps, early ends, ties and random back-pressure
    rdy_mode = 1;
    for (int f = 0; f < 500; f++) begin
      len = $urandom_range(1, NI);
      hi  = (f % 3 == 0) ? 3 : 255;
      sel = 1'($urandom_range(0, 1));
      q   = {};
      for (int k = 0; k < len; k++) q.push_back(8'($urandom_range(0, hi)));
      send_frame(q, sel, 2);
    end
    rdy_mode = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
